// File: rtl/clk_sw_pkg.sv
// Shared definitions for the clock-switch controller: FSM encoding, default
// parameters and the timeout counter width helper.
package clk_sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2
  } state_e;

  localparam int DEF_NUM_SRC     = 2;
  localparam int DEF_SEL_W       = 1;
  localparam int DEF_RESET_SRC   = 0;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 64;

  // The counter only has to reach cycles-1 before the phase is abandoned.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop synchroniser for a vector of quasi-static asynchronous flags.
module sync_nff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbour, which is what forms the shift chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/clk_switch_ctrl.sv
// Initiator of the glitch-free clock-select handshake (break-before-make with
// timeout supervision). Define CLK_SW_AUTO_RETRY_EN to retry one timeout.
module clk_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int NUM_SRC     = DEF_NUM_SRC,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int RESET_SRC   = DEF_RESET_SRC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_src,
  output logic               req_ready,
  output logic [NUM_SRC-1:0] sel_oh,
  input  logic [NUM_SRC-1:0] mux_status,
  output logic [SEL_W-1:0]   cur_src,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               err_bad_src
);

  localparam int             CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    for (int i = 0; i < NUM_SRC; i++) v[i] = (int'(idx) == i);
    return v;
  endfunction

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] st;
  logic [NUM_SRC-1:0] sel_q, sel_d;
  logic [SEL_W-1:0]   cur_q, cur_d, tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d, tmo_q, tmo_d, bad_q, bad_d;
  logic               bad, same, go, exit_ok, expired, timeout, retry_now;

  sync_nff #(.STAGES(SYNC_STAGES), .WIDTH(NUM_SRC)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (mux_status),
    .q   (st)
  );

`ifdef CLK_SW_AUTO_RETRY_EN
  logic retry_q;
  assign retry_now = !retry_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   retry_q <= 1'b0;
    else if (state_q == ST_IDLE) retry_q <= 1'b0;
    else if (timeout)           retry_q <= 1'b1;
  end
`else
  assign retry_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sel_q   <= onehot(SEL_W'(RESET_SRC));
      cur_q   <= SEL_W'(RESET_SRC);
      tgt_q   <= SEL_W'(RESET_SRC);
      cnt_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      bad_q   <= bad_d;
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    bad     = 1'b0;
    same    = 1'b0;
    go      = 1'b0;
    exit_ok = 1'b0;
    expired = (cnt_q == CNT_LAST);
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (int'(req_src) >= NUM_SRC) bad  = 1'b1;
          else if (req_src == cur_q)    same = 1'b1;
          else begin
            go      = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        exit_ok = (st == '0);
        if (exit_ok)      state_d = ST_MAKE;
        else if (expired) state_d = retry_now ? ST_BREAK : ST_IDLE;
      end
      ST_MAKE: begin
        exit_ok = (st == onehot(tgt_q));
        if (exit_ok)      state_d = ST_IDLE;
        else if (expired) state_d = retry_now ? ST_BREAK : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    timeout = (state_q != ST_IDLE) && !exit_ok && expired;
  end

  always_comb begin
    sel_d  = sel_q;
    cur_d  = cur_q;
    tgt_d  = tgt_q;
    cnt_d  = (state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;
    done_d = same;
    bad_d  = bad;
    tmo_d  = 1'b0;
    if (go) begin
      tgt_d = req_src;
      sel_d = '0;
    end
    if (state_q == ST_BREAK && exit_ok) begin
      sel_d = onehot(tgt_q);
      cnt_d = '0;
    end
    if (state_q == ST_MAKE && exit_ok) begin
      cur_d  = tgt_q;
      done_d = 1'b1;
    end
    // A failed phase falls back to the last good source unless a retry is due.
    if (timeout) begin
      cnt_d = '0;
      if (retry_now) sel_d = '0;
      else begin
        tmo_d = 1'b1;
        sel_d = onehot(cur_q);
      end
    end
  end

  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    sel_oh      = sel_q;
    cur_src     = cur_q;
    done        = done_q;
    err_timeout = tmo_q;
    err_bad_src = bad_q;
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Randomised bench for clk_switch_ctrl: a delay-line mux model with fault
// modes, and per-transaction expectations from the handshake timing rules.
module tb_clk_switch_ctrl;

  localparam int NUM_SRC = 3;
  localparam int SEL_W   = 2;
  localparam int SYNC    = 2;
  localparam int T       = 16;
  localparam int HD      = 16;
`ifdef CLK_SW_AUTO_RETRY_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic [SEL_W-1:0]   req_src;
  logic               req_ready;
  logic [NUM_SRC-1:0] sel_oh;
  logic [NUM_SRC-1:0] mux_status;
  logic [SEL_W-1:0]   cur_src;
  logic               busy, done, err_timeout, err_bad_src;

  int n_checks = 0;
  int n_errors = 0;

  clk_switch_ctrl #(
    .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .RESET_SRC(0),
    .SYNC_STAGES(SYNC), .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_src(req_src),
    .req_ready(req_ready), .sel_oh(sel_oh), .mux_status(mux_status),
    .cur_src(cur_src), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_bad_src(err_bad_src)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_SRC-1:0] oh(input int i);
    logic [NUM_SRC-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Mux model: status echoes sel_oh delayed by mux_d samples.
  // mode 1 never drops the old source; mode 2 also leaves the old one on.
  logic [NUM_SRC-1:0] hist [HD];
  logic [NUM_SRC-1:0] dl;
  int mux_d = 0, mux_mode = 0, mux_old = 0, mux_tgt = 0;
  int cur_m = 0;

  always @(negedge clk) begin
    for (int i = HD - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sel_oh;
    dl = hist[mux_d];
    case (mux_mode)
      1:       mux_status = (dl == '0) ? oh(mux_old) : dl;
      2:       mux_status = (dl == oh(mux_tgt)) ? (dl | oh(mux_old)) : dl;
      default: mux_status = dl;
    endcase
  end

  task automatic gap();
    req_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int src, input int mode, input int d);
    int  b, phase, end_k;
    bit  bad, same;
    logic [NUM_SRC-1:0] exp_sel;
    bad  = (src >= NUM_SRC);
    same = !bad && (src == cur_m);
    if (!bad && !same) begin
      mux_d = d; mux_mode = mode; mux_old = cur_m; mux_tgt = src;
    end
    check("ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_src   = SEL_W'(src);
    @(posedge clk); #1;
    if (bad || same) begin
      req_valid = 1'b0;
      check("bad_pulse", err_bad_src, bad);
      check("same_done", done, same);
      check("sel_hold", sel_oh, oh(cur_m));
      check("idle_busy", busy, 0);
      @(posedge clk); #1;
      check("pulse_end", {done, err_bad_src, err_timeout}, 0);
      check("sel_hold2", sel_oh, oh(cur_m));
      gap();
      return;
    end
    b     = SYNC + d + 1;
    phase = b + T;
    case (mode)
      0:       end_k = 2 * b;
      1:       end_k = T * (RETRY + 1);
      default: end_k = phase * (RETRY + 1);
    endcase
    for (int k = 0; k <= end_k; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (k == end_k)    exp_sel = (mode == 0) ? oh(src) : oh(cur_m);
      else if (mode == 1) exp_sel = '0;
      else if (mode == 0) exp_sel = (k < b) ? '0 : oh(src);
      else               exp_sel = ((k % phase) < b) ? '0 : oh(src);
      check("sel", sel_oh, exp_sel);
      check("busy", busy, k < end_k);
      check("ready", req_ready, k == end_k);
      check("done", done, (k == end_k) && (mode == 0));
      check("timeout", err_timeout, (k == end_k) && (mode != 0));
      check("bad_quiet", err_bad_src, 0);
      check("cur", cur_src, ((k == end_k) && (mode == 0)) ? src : cur_m);
      // Requests while busy must be ignored.
      if (k < end_k) begin
        req_valid = 1'($urandom_range(0, 1));
        req_src   = SEL_W'($urandom_range(0, 3));
      end else req_valid = 1'b0;
    end
    if (mode == 0) cur_m = src;
    @(posedge clk); #1;
    check("pulse_once", {done, err_timeout}, 0);
    mux_mode = 0;
    gap();
  endtask

  initial begin
    for (int i = 0; i < HD; i++) hist[i] = oh(0);
    mux_status = oh(0);
    rst = 1'b0; req_valid = 1'b0; req_src = '0;
    #12;
    check("rst_sel", sel_oh, oh(0));
    check("rst_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("post_rst_sel", sel_oh, oh(0));
    check("post_rst_cur", cur_src, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_pulses", {done, err_timeout, err_bad_src}, 0);

    do_req(1, 0, 3);          // normal switch 0 -> 1
    do_req(1, 0, 0);          // same source
    do_req(3, 0, 0);          // bad index
    do_req(0, 1, 2);          // break phase never completes
    do_req(2, 0, 13);         // exit exactly on the last counted cycle
    do_req(0, 2, 1);          // wrong source enabled in make

    // Asynchronous reset in the middle of the make phase.
    mux_d = 4; mux_mode = 0; mux_old = cur_m; mux_tgt = (cur_m + 1) % NUM_SRC;
    req_valid = 1'b1; req_src = SEL_W'(mux_tgt);
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (SYNC + 4 + 3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("amid_sel", sel_oh, oh(0));
    check("amid_cur", cur_src, 0);
    check("amid_busy", busy, 0);
    check("amid_ready", req_ready, 1);
    check("amid_pulses", {done, err_timeout, err_bad_src}, 0);
    cur_m = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    gap();
    do_req(1, 0, 2);

    for (int n = 0; n < 30; n++) begin
      int src, mode, d;
      src  = $urandom_range(0, 3);
      mode = ($urandom_range(0, 5) < 3) ? 0 : $urandom_range(1, 2);
      d    = $urandom_range(0, 5);
      do_req(src, mode, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
